// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  decoder_pkg
//  Shared types and constants for the decoder dispatch block.
//  Revision: 1.0
// ============================================================================
package decoder_pkg;

  localparam int CODE_W_DEFAULT   = 3;
  localparam int OUT_W_DEFAULT    = 1 << CODE_W_DEFAULT;
  localparam int MIN_HOLD_DEFAULT = 2;
  localparam int MIN_HOLD_MAX     = 15;

  // Hold counter must reach MIN_HOLD_MAX-1, so 4 bits is enough.
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
//  onehot_dec
//  Combinational binary-index to one-hot decoder.
//  Revision: 1.0
// ============================================================================
module onehot_dec #(
  parameter int CODE_W = 3,
  parameter int OUT_W  = 8
) (
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  onehot
);

  // Exactly one bit set, at the position named by code.
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/decoder_dispatch.sv
`default_nettype none
// ============================================================================
//  decoder_dispatch
//  Captures an encoded index, presents it as a registered one-hot word for a
//  guaranteed minimum number of cycles, then waits for a downstream ack.
//  Dropping en cancels a dispatch in flight and pulses aborted.
//  Revision: 1.0
// ============================================================================
module decoder_dispatch
  import decoder_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEFAULT,
  parameter int OUT_W    = OUT_W_DEFAULT,
  parameter int MIN_HOLD = MIN_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  input  logic              y_ack,
  output logic              aborted,
  output logic [7:0]        dispatch_cnt
);

  localparam logic [HOLD_CNT_W-1:0] c_HOLD_LOAD = HOLD_CNT_W'(MIN_HOLD - 1);

  state_t                r_state;
  state_t                w_next;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [OUT_W-1:0]      w_onehot;
  logic                  w_xfer;
  logic                  w_abort;
  logic                  w_ack;

  onehot_dec #(
    .CODE_W (CODE_W),
    .OUT_W  (OUT_W)
  ) u_onehot_dec (
    .code   (in_code),
    .onehot (w_onehot)
  );

  // Only an idle, enabled block can take a new code.
  assign in_ready = en && (r_state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort by en low outranks an ack in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_xfer  = 1'b0;
    w_abort = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && in_valid) begin
          w_xfer = 1'b1;
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (r_hold_cnt == '0) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (y_ack) begin
          w_ack  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output word, hold countdown, abort pulse and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y            <= '0;
      y_valid      <= 1'b0;
      aborted      <= 1'b0;
      r_hold_cnt   <= '0;
      dispatch_cnt <= 8'd0;
    end else begin
      aborted <= w_abort;
      if (w_xfer) begin
        y          <= w_onehot;
        y_valid    <= 1'b1;
        r_hold_cnt <= c_HOLD_LOAD;
      end else if (w_abort || w_ack) begin
        y          <= '0;
        y_valid    <= 1'b0;
        r_hold_cnt <= '0;
        if (w_ack) begin
          dispatch_cnt <= dispatch_cnt + 8'd1;
        end
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_dispatch.sv
`default_nettype none
// ============================================================================
//  tb_decoder_dispatch
//  Directed stimulus with a cycle-level reference model and literal checks.
//  Revision: 1.0
// ============================================================================
module tb_decoder_dispatch;

  localparam int MIN_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       y_ack = 1'b0;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       aborted;
  logic [7:0] dispatch_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  decoder_dispatch #(
    .CODE_W   (3),
    .OUT_W    (8),
    .MIN_HOLD (MIN_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_valid     (in_valid),
    .in_code      (in_code),
    .in_ready     (in_ready),
    .y            (y),
    .y_valid      (y_valid),
    .y_ack        (y_ack),
    .aborted      (aborted),
    .dispatch_cnt (dispatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dispatch is "busy" with an age counted from the
  // first cycle y is visible; an ack only counts once age exceeds MIN_HOLD.
  bit         m_busy  = 1'b0;
  logic [2:0] m_code  = 3'd0;
  int         m_age   = 0;
  int         m_cnt   = 0;
  bit         m_abort = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_cnt = 0; m_abort = 1'b0;
    end else begin
      m_abort = 1'b0;
      if (m_busy) begin
        if (!en) begin
          m_busy  = 1'b0;
          m_abort = 1'b1;
        end else if (m_age > MIN_HOLD && y_ack) begin
          m_busy = 1'b0;
          m_cnt  = (m_cnt + 1) % 256;
        end else begin
          m_age++;
        end
      end else if (en && in_valid) begin
        m_busy = 1'b1;
        m_code = in_code;
        m_age  = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] exp_y;
    if (!rst && chk_on) begin
      exp_y = m_busy ? (8'h01 << m_code) : 8'h00;
      chk("y", y, exp_y);
      chk("y_valid", y_valid, m_busy);
      chk("in_ready", in_ready, en && !m_busy);
      chk("aborted", aborted, m_abort);
      chk("dispatch_cnt", dispatch_cnt, m_cnt[7:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdy_bad;

    // Reset
    repeat (2) step();
    rst = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_y", y, 8'h00);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_cnt", dispatch_cnt, 8'd0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_ready_en0", in_ready, 1'b0);
    en = 1'b1;
    #1;
    chk("ready_en1", in_ready, 1'b1);

    // Code 5 with ack held high: y=8'h20 for exactly 3 cycles
    step();
    in_valid = 1'b1; in_code = 3'd5; y_ack = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (y == 8'h20) n++;
    end
    chk("code5_cycles", n, 3);
    chk("code5_cnt", dispatch_cnt, 8'd1);
    chk("code5_cleared", y, 8'h00);
    step();

    // Code 0 with a long wait for ack
    in_valid = 1'b1; in_code = 3'd0; y_ack = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0; rdy_bad = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (y == 8'h01) n++;
      if (in_ready) rdy_bad++;
      step();
    end
    y_ack = 1'b1;
    @(negedge clk);
    if (y == 8'h01) n++;
    if (in_ready) rdy_bad++;
    step();
    y_ack = 1'b0;
    @(negedge clk);
    chk("code0_cycles", n, 12);
    chk("code0_ready_low", rdy_bad, 0);
    chk("code0_cleared", y, 8'h00);
    chk("code0_cnt", dispatch_cnt, 8'd2);
    step();

    // Abort during HOLD with ack high
    in_valid = 1'b1; in_code = 3'd2; y_ack = 1'b1;
    step();
    in_valid = 1'b0;
    en = 1'b0;
    step();
    @(negedge clk);
    chk("abort_pulse", aborted, 1'b1);
    chk("abort_y", y, 8'h00);
    chk("abort_cnt", dispatch_cnt, 8'd2);
    step();
    @(negedge clk);
    chk("abort_pulse_end", aborted, 1'b0);
    step();
    en = 1'b1; y_ack = 1'b0;
    step();

    // Changing code while busy must not be captured
    in_valid = 1'b1; in_code = 3'd6;
    step();
    for (int k = 0; k < 6; k++) begin
      in_code = 3'(k);
      @(negedge clk);
      chk("busy_hold_y", y, 8'h40);
      step();
    end
    y_ack = 1'b1; in_code = 3'd1;
    step();
    in_code = 3'd3; y_ack = 1'b0;
    step();
    in_valid = 1'b0; y_ack = 1'b1;
    @(negedge clk);
    chk("recapture_y", y, 8'h08);
    repeat (3) step();
    y_ack = 1'b0;
    step();

    // Async reset in the middle of WAIT
    in_valid = 1'b1; in_code = 3'd4;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #1;
    rst = 1'b1;
    #1;
    chk("async_y", y, 8'h00);
    chk("async_y_valid", y_valid, 1'b0);
    chk("async_aborted", aborted, 1'b0);
    chk("async_cnt", dispatch_cnt, 8'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_code = 3'd3; y_ack = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_code3", y, 8'h08);
    repeat (3) step();
    y_ack = 1'b0;

    // 256 acknowledged dispatches from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    y_ack = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_code = 3'(i % 8);
      step();
      in_valid = 1'b0;
      repeat (MIN_HOLD + 1) step();
    end
    y_ack = 1'b0;
    @(negedge clk);
    chk("wrap_cnt", dispatch_cnt, 8'd0);
    chk("wrap_idle_ready", in_ready, 1'b1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
